// File: rtl/delay_stream_pkg.sv
// delay_stream_pkg: width derivations and delay clamp shared by delay_stream and delay_line
package delay_stream_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ptr_width(input int depth);
    return depth > 1 ? clog2(depth) : 1;
  endfunction
  function automatic int delay_width(input int depth);
    return clog2(depth + 1);
  endfunction
  function automatic int fill_width(input int taps, input int depth);
    return clog2((taps - 1) * depth + 1);
  endfunction
  function automatic int clamp_delay(input int v, input int depth);
    return v < 1 ? 1 : v > depth ? depth : v;
  endfunction
endpackage

// File: rtl/delay_line.sv
// delay_line: line buffer ring with combinational read-before-write at an external pointer
module delay_line
  import delay_stream_pkg::*;
#(
  parameter int IMG_WIDTH = 8,
  parameter int MEM_DEPTH = 15,
  parameter int PTR_W = ptr_width(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [PTR_W-1:0]     ptr_i,
  input  logic [IMG_WIDTH-1:0] wdata_i,
  output logic [IMG_WIDTH-1:0] rdata_o
);
  logic [IMG_WIDTH-1:0] mem_q [MEM_DEPTH];
  assign rdata_o = mem_q[ptr_i];
  // contents survive reset and reconfiguration; the top masks or gates stale entries
  always_ff @(posedge clk)
    if (we_i) mem_q[ptr_i] <= wdata_i;
endmodule

// File: rtl/delay_stream.sv
// delay_stream: multi-tap streaming line delay with ready/valid; define DELAY_STREAM_PRIME_EN to hold dn_val until all taps are primed
module delay_stream
  import delay_stream_pkg::*;
#(
  parameter int HEIGHT_NB  = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 8,
  parameter int MEM_DEPTH  = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [MEM_AWIDTH-1:0]          cfg_delay,
  input  logic                           cfg_set,
  input  logic [IMG_WIDTH-1:0]           up_data,
  input  logic                           up_val,
  output logic                           up_rdy,
  output logic [IMG_WIDTH*HEIGHT_NB-1:0] dn_data,
  output logic                           dn_val,
  input  logic                           dn_rdy
);
  localparam int PTR_W  = ptr_width(MEM_DEPTH);
  localparam int D_W    = delay_width(MEM_DEPTH);
  localparam int FILL_W = fill_width(HEIGHT_NB, MEM_DEPTH);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [D_W-1:0] d_q, d_d;
  logic [FILL_W-1:0] fill_q, fill_d, prime;
  logic [HEIGHT_NB-1:0][IMG_WIDTH-1:0] tap, tap_m;
  logic [IMG_WIDTH*HEIGHT_NB-1:0] data_q, data_d;
  logic val_q, val_d, accept, primed;
  assign up_rdy  = !rst && !cfg_set && (!val_q || dn_rdy);
  assign accept  = up_val && up_rdy;
  assign dn_data = data_q;
  assign dn_val  = val_q;
  assign tap[0]  = up_data;
  for (genvar k = 0; k < HEIGHT_NB - 1; k++) begin : g_line
    delay_line #(.IMG_WIDTH(IMG_WIDTH), .MEM_DEPTH(MEM_DEPTH), .PTR_W(PTR_W)) u_line (
      .clk    (clk),
      .we_i   (accept),
      .ptr_i  (ptr_q),
      .wdata_i(tap[k]),
      .rdata_o(tap[k+1])
    );
  end
  for (genvar k = 0; k < HEIGHT_NB; k++) begin : g_mask
`ifdef DELAY_STREAM_PRIME_EN
    assign tap_m[k] = tap[k];
`else
    assign tap_m[k] = (fill_q >= FILL_W'(k * int'(d_q))) ? tap[k] : '0;
`endif
  end
`ifdef DELAY_STREAM_PRIME_EN
  assign primed = fill_q >= prime;
`else
  assign primed = 1'b1;
`endif
  // next state: pointer ring, saturating fill, delay latch and output register
  always_comb begin
    prime  = FILL_W'((HEIGHT_NB - 1) * int'(d_q));
    d_d    = cfg_set ? D_W'(clamp_delay(int'(cfg_delay), MEM_DEPTH)) : d_q;
    ptr_d  = cfg_set ? '0 : !accept ? ptr_q : (ptr_q == PTR_W'(d_q - 1'b1)) ? '0 : ptr_q + 1'b1;
    fill_d = cfg_set ? '0 : (accept && fill_q < prime) ? fill_q + 1'b1 : fill_q;
    data_d = accept ? tap_m : data_q;
    val_d  = cfg_set ? 1'b0 : accept ? primed : dn_rdy ? 1'b0 : val_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk)
    if (rst) begin
      d_q    <= D_W'(MEM_DEPTH);
      ptr_q  <= '0;
      fill_q <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
    end else begin
      d_q    <= d_d;
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
      data_q <= data_d;
      val_q  <= val_d;
    end
endmodule

// File: tb/tb_delay_stream.sv
// tb_delay_stream: randomized and directed stimulus checked against a sample-history reference model
module tb_delay_stream;
  localparam int H = 3;
  localparam int W = 8;
  localparam int DEPTH = 15;
`ifdef DELAY_STREAM_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif
  logic clk, rst, cfg_set, up_val, up_rdy, dn_val, dn_rdy;
  logic [7:0] cfg_delay;
  logic [W-1:0] up_data;
  logic [W*H-1:0] dn_data;
  int checks = 0, failures = 0, outs = 0;
  logic [W-1:0] hist [$];
  logic [W*H-1:0] exp_data = '0;
  logic exp_val = 1'b0, dat_ok = 1'b1, rdy_e, acc = 1'b0;
  int dly = DEPTH, n, idx;
  logic [W-1:0] seq = 8'd1;

  delay_stream #(.HEIGHT_NB(H), .IMG_WIDTH(W), .MEM_AWIDTH(8), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_delay(cfg_delay), .cfg_set(cfg_set),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one cycle of stimulus; sequential data advances only when the previous beat was taken
  task automatic cyc(input bit v, input bit r, input bit c = 0, input logic [7:0] cd = 0,
                     input bit rs = 0, input bit rnd = 0);
    if (acc) seq++;
    up_val = v; dn_rdy = r; cfg_set = c; cfg_delay = cd; rst = rs;
    up_data = rnd ? 8'($urandom) : seq;
    @(posedge clk); #1;
  endtask

  // reference model: expected outputs from the history of samples accepted since the last reset/reconfig
  always @(negedge clk) begin
    chk("dn_val", {31'd0, dn_val}, {31'd0, exp_val});
    if (dat_ok) chk("dn_data", 32'(dn_data), 32'(exp_data));
    rdy_e = !rst && !cfg_set && (!exp_val || dn_rdy);
    chk("up_rdy", {31'd0, up_rdy}, {31'd0, rdy_e});
    if (dn_val && dn_rdy) outs++;
    acc = 1'b0;
    if (rst) begin
      exp_val = 1'b0; exp_data = '0; dat_ok = 1'b1; dly = DEPTH; hist.delete();
    end else if (cfg_set) begin
      exp_val = 1'b0; hist.delete();
      dly = cfg_delay == 0 ? 1 : cfg_delay > DEPTH ? DEPTH : int'(cfg_delay);
    end else if (up_val && rdy_e) begin
      acc = 1'b1; n = hist.size(); dat_ok = 1'b1;
      for (int k = 0; k < H; k++) begin
        idx = n - k * dly;
        if (idx < 0) begin
          exp_data[k*W +: W] = '0;
          if (PRIME) dat_ok = 1'b0;
        end else exp_data[k*W +: W] = (k == 0) ? up_data : hist[idx];
      end
      exp_val = PRIME ? (n >= (H - 1) * dly) : 1'b1;
      hist.push_back(up_data);
    end else if (dn_rdy) exp_val = 1'b0;
  end

  initial begin
    rst = 1'b1; cfg_set = 1'b0; cfg_delay = '0; up_val = 1'b0; up_data = '0; dn_rdy = 1'b0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 1, 8'd10);
    seq = 8'd1; outs = 0;
    for (int i = 0; i < 30; i++) cyc(1, 1);
    cyc(0, 1);
    chk("nbeats_d10", 32'(outs), PRIME ? 32'd10 : 32'd30);
    for (int i = 0; i < 5; i++) cyc(0, 1);
    for (int i = 0; i < 30; i++) cyc(1, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1);
    cyc(0, 1, 1, 8'd0);
    for (int i = 0; i < 12; i++) cyc(1, 1);
    for (int i = 0; i < 30; i++) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    cyc(0, 1, 1, 8'd20);
    for (int i = 0; i < 60; i++) cyc(1, $urandom_range(0, 4) != 0);
    cyc(0, 1, 1, 8'd4);
    seq = 8'd1;
    for (int i = 0; i < 12; i++) cyc(1, 1);
    cyc(1, 1, 1, 8'd4);
    for (int i = 0; i < 12; i++) cyc(1, 1);
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) cyc(1, 1);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20)),
          $urandom_range(0, 400) == 0, 1);
    cyc(0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/delay_stream.md
# delay_stream

Multi-tap streaming line delay with ready/valid flow control. Given one pixel stream, it presents HEIGHT_NB vertically aligned samples per output beat: the current sample and samples delayed by 1..HEIGHT_NB-1 configurable line lengths. It sits between the pixel source and the window/filter kernels. It generalises the free-running delay block with backpressure, delay clamping, priming control and synchronous reset.

## Interface
- HEIGHT_NB, 3, number of output taps (≥2)
- IMG_WIDTH, 8, bits per sample
- MEM_AWIDTH, 8, width of cfg_delay
- MEM_DEPTH, 15, maximum line length per tap (entries per line buffer)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_delay  in  MEM_AWIDTH  requested line length in beats
- cfg_set  in  1  one-cycle strobe that loads cfg_delay
- up_data  in  IMG_WIDTH  input sample
- up_val  in  1  input valid
- up_rdy  out  1  input ready
- dn_data  out  IMG_WIDTH*HEIGHT_NB  tap k at [k*IMG_WIDTH +: IMG_WIDTH]; tap 0 = newest
- dn_val  out  1  output valid
- dn_rdy  in  1  output ready

## Operation
- One clock domain; reset is synchronous and active-high.
- Effective delay D = clamp(cfg_delay, 1, MEM_DEPTH), latched on cfg_set. After reset D = MEM_DEPTH.
- An up beat is accepted when up_val && up_rdy. up_rdy = !rst && !cfg_set && (!dn_val || dn_rdy).
- On an accepted beat n: tap 0 = sample n, tap k = sample n − k·D. Every line buffer reads and writes at a shared pointer. The pointer increments per accepted beat and wraps from D−1 to 0. Tap k+1 takes the old entry of buffer k, which is then overwritten with tap k.
- Idle cycles (up_val low) do not advance the pointer. Delay counts beats, not cycles.
- Fill counter counts accepted beats and saturates at P = (HEIGHT_NB−1)·D. Width is clog2((HEIGHT_NB−1)·MEM_DEPTH+1).
- cfg_set clears the pointer and fill counter and drops dn_val. Buffer contents are not cleared. cfg_set wins over a simultaneous up beat, which is not accepted.
- Output register: loaded on an accepted beat, and dn_val set per priming rule. Held while dn_val && !dn_rdy. Cleared to dn_val=0 when dn_rdy is high and no beat is accepted.
- Reset values: dn_data=0, dn_val=0, up_rdy=0, pointer=0, fill=0, D=MEM_DEPTH.
- Reset mid-stream aborts the in-flight output beat and discards history.

## Timing
- Latency 1 cycle: beat accepted at edge t appears on dn_data/dn_val after edge t.
- Full throughput 1 beat/cycle while dn_rdy stays high.
- Under stall, dn_data and dn_val stay stable until dn_rdy is seen high. A downstream stall backs up to up_rdy in the same cycle (combinational).
- D=1 is legal: tap k = sample n−k, with back-to-back accept.

## Configuration
- DELAY_STREAM_PRIME_EN defined: dn_val asserts only for beats accepted once fill ≥ P. The first output after reset or cfg_set is the (P+1)-th accepted beat.
- Not defined: every accepted beat produces dn_val=1. Tap k is forced to 0 while fill < k·D, so stale buffer contents are never exposed.

## Structure
- Shared package/header delay_stream_pkg: clog2 function, fill-width and pointer-width localparam derivations, and the clamp function.
- One sub-module, delay_line: a MEM_DEPTH×IMG_WIDTH ring with combinational read-before-write at an external pointer and write enable. It is instantiated HEIGHT_NB−1 times in a chain. Pointer, fill, clamp and handshake logic stay in the top level.

## Test plan
- PRIME_EN, D=10, send 1..30 continuous, dn_rdy=1 → first dn_val carries {tap2,tap1,tap0}={1,11,21}. The last beat carries {10,20,30}. There are exactly 10 output beats.
- PRIME_EN off, same stimulus → 30 output beats. Beat 1 = {0,0,1}, beat 11 = {0,1,11}, beat 21 = {1,11,21}.
- Gap of 5 idle cycles, then 31..60 → output continues with no skew. Beat 31 = {11,21,31}.
- dn_rdy low for 4 cycles mid-stream with up_val high → dn_data/dn_val frozen, up_rdy=0, and no sample lost or duplicated after release.
- cfg_set with cfg_delay=0, then 20 → D=1, then D=15. With PRIME_EN, after D=4 the first output comes on beat 9 = {1,5,9}. A cfg_set coincident with up_val drops that beat.
- rst asserted mid-stream for 1 cycle → all outputs at reset values next cycle. D returns to 15 and priming restarts.
